// File: rtl/pci_bus_arbiter_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM state encoding and index-width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pci_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,   // bus parked on PARK_MASTER, nobody requesting
      ST_SWITCH = 2'd1,   // one-cycle all-ones Gnt gap before handing over
      ST_GRANT  = 2'd2,   // Gnt asserted, waiting for the grantee to start
      ST_BUSY   = 2'd3    // transaction in flight on the shared bus
   } arb_state_t;

   // Width of a master index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin picker over active-low request lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever any request line is low.
//
// Ports:
//   req_n : active-low requests, bit i = master i
//   ptr   : last serviced master; search starts at ptr+1 and wraps
//   valid : at least one request is low
//   idx   : first requesting master found from ptr+1 upward
module pci_bus_arbiter_rr_pick
   import pci_bus_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   localparam int IDX_W       = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_n,
   input  logic [IDX_W-1:0]       ptr,
   output logic                   valid,
   output logic [IDX_W-1:0]       idx
);

   // One extra bit so ptr+k (at most 2*NUM_MASTERS-1) never overflows before the wrap.
   localparam logic [IDX_W:0] N_L = (IDX_W+1)'(NUM_MASTERS);

   logic [IDX_W:0] w_cand;

   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      w_cand = '0;
      // k runs 1..N so the current pointer holder is considered last.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (w_cand >= N_L) begin
            w_cand = w_cand - N_L;
         end
         if (!valid && !req_n[w_cand[IDX_W-1:0]]) begin
            valid = 1'b1;
            idx   = w_cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin over active-low Req, single active-low Gnt, parking on PARK_MASTER.
// Latency: all outputs registered; a decision taken on edge N is visible right after edge N.
// Backpressure: never cuts a running transaction; Gnt is only withdrawn (never moved) while Frame/Irdy show a busy bus.
//
// Ports:
//   Clock   : bus clock, rising edge
//   RST     : synchronous active-low reset
//   Req     : active-low requests, bit i = master i (X/undriven treated as deasserted)
//   Frame   : active-low PCI Frame
//   Irdy    : active-low PCI Irdy
//   Gnt     : active-low grants, at most one bit low
//   Owner   : index of current/last grantee
//   BusIdle : registered Frame && Irdy
module pci_bus_arbiter
   import pci_bus_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   parameter  int PARK_MASTER = 0,
   parameter  int GNT_TIMEOUT = 16,
   localparam int IDX_W       = idx_w(NUM_MASTERS)
) (
   input  logic                   Clock,
   input  logic                   RST,
   input  logic [NUM_MASTERS-1:0] Req,
   input  logic                   Frame,
   input  logic                   Irdy,
   output logic [NUM_MASTERS-1:0] Gnt,
   output logic [IDX_W-1:0]       Owner,
   output logic                   BusIdle
);

   localparam int               TMR_W    = $clog2(GNT_TIMEOUT + 1);
   localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);

   arb_state_t             r_state, w_state_nxt, w_arb_state;
   logic [IDX_W-1:0]       r_owner, w_owner_nxt, w_arb_owner;
   logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
   logic [TMR_W-1:0]       r_timer, w_timer_nxt;
   logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
   logic                   r_bus_idle;

   logic [NUM_MASTERS-1:0] w_req_act;
   logic [NUM_MASTERS-1:0] w_req_n;
   logic                   w_idle;
   logic                   w_timeout;
   logic                   w_owner_req;
   logic                   w_other_req;
   logic [IDX_W-1:0]       w_pick_ptr;
   logic                   w_pick_vld;
   logic [IDX_W-1:0]       w_pick_idx;

   // Only a solid 0 counts as a request; X/Z fall into the else branch.
   always_comb begin
      w_req_act = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (Req[i] == 1'b0) begin
            w_req_act[i] = 1'b1;
         end else begin
            w_req_act[i] = 1'b0;
         end
      end
   end

   assign w_req_n     = ~w_req_act;
   assign w_idle      = Frame & Irdy;
   assign w_owner_req = w_req_act[r_owner];
   assign w_timeout   = (r_state == ST_GRANT) && w_idle && (r_timer == TMR_LAST);

   // On timeout the pointer moves to Owner in the same edge, so the search
   // must already start from Owner or the timed-out master would keep priority.
   assign w_pick_ptr = w_timeout ? r_owner : r_ptr;

   pci_bus_arbiter_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .req_n (w_req_n),
      .ptr   (w_pick_ptr),
      .valid (w_pick_vld),
      .idx   (w_pick_idx)
   );

   // Common rearbitration target. Returning to park from another master goes
   // through SWITCH aimed at PARK_MASTER, so Gnt still gets its all-ones gap;
   // SWITCH then drops into PARK because the park master is not requesting.
   always_comb begin
      if (w_pick_vld) begin
         w_arb_state = ST_SWITCH;
         w_arb_owner = w_pick_idx;
      end else if (r_owner == PARK_IDX) begin
         w_arb_state = ST_PARK;
         w_arb_owner = PARK_IDX;
      end else begin
         w_arb_state = ST_SWITCH;
         w_arb_owner = PARK_IDX;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_timer_nxt = '0;
      case (r_state)
         ST_PARK: begin
            // A parked master may start without requesting; follow it.
            if (!Frame) begin
               w_state_nxt = ST_BUSY;
               w_owner_nxt = PARK_IDX;
            end else if (w_pick_vld) begin
               w_owner_nxt = w_pick_idx;
               w_state_nxt = (w_pick_idx == PARK_IDX) ? ST_GRANT : ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            // Requests arriving now wait for the next arbitration.
            if (w_owner_req) begin
               w_state_nxt = ST_GRANT;
            end else begin
               w_state_nxt = ST_PARK;
               w_owner_nxt = PARK_IDX;
            end
         end
         ST_GRANT: begin
            if (!Frame) begin
               w_state_nxt = ST_BUSY;
               w_ptr_nxt   = r_owner;
            end else if (w_timeout) begin
               w_ptr_nxt   = r_owner;
               w_state_nxt = w_arb_state;
               w_owner_nxt = w_arb_owner;
            end else if (!w_owner_req) begin
               w_state_nxt = w_arb_state;
               w_owner_nxt = w_arb_owner;
            end else if (w_idle) begin
               w_timer_nxt = r_timer + 1'b1;
            end else begin
               w_timer_nxt = r_timer;
            end
         end
         ST_BUSY: begin
            if (w_idle) begin
               if (w_pick_vld && (w_pick_idx == r_owner)) begin
                  w_state_nxt = ST_GRANT;
               end else begin
                  w_state_nxt = w_arb_state;
                  w_owner_nxt = w_arb_owner;
               end
            end
         end
         default: begin
            w_state_nxt = ST_PARK;
            w_owner_nxt = PARK_IDX;
         end
      endcase
   end

   // Gnt follows the state being entered. In BUSY the owner's Gnt is pulled
   // whenever someone else waits, so its latency timer ends the burst.
   always_comb begin
      w_gnt_nxt   = '1;
      w_other_req = |(w_req_act & ~(NUM_MASTERS'(1) << w_owner_nxt));
      case (w_state_nxt)
         ST_PARK:  w_gnt_nxt[PARK_IDX]    = 1'b0;
         ST_GRANT: w_gnt_nxt[w_owner_nxt] = 1'b0;
         ST_BUSY: begin
            if (!w_other_req) begin
               w_gnt_nxt[w_owner_nxt] = 1'b0;
            end
         end
         default: w_gnt_nxt = '1;
      endcase
   end

   // Reset drops Gnt immediately, even mid-transaction.
   always_ff @(posedge Clock) begin
      if (!RST) begin
         r_state    <= ST_PARK;
         r_owner    <= PARK_IDX;
         r_ptr      <= PARK_IDX;
         r_timer    <= '0;
         r_gnt      <= '1;
         r_bus_idle <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_ptr      <= w_ptr_nxt;
         r_timer    <= w_timer_nxt;
         r_gnt      <= w_gnt_nxt;
         r_bus_idle <= w_idle;
      end
   end

   assign Gnt     = r_gnt;
   assign Owner   = r_owner;
   assign BusIdle = r_bus_idle;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: parking, round-robin order, busy-bus release, timeout, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pci_bus_arbiter;

   logic       Clock;
   logic       RST;
   logic [3:0] Req;
   logic       Frame;
   logic       Irdy;
   logic [3:0] Gnt;
   logic [1:0] Owner;
   logic       BusIdle;

   int n_pass  = 0;
   int n_total = 0;

   pci_bus_arbiter #(
      .NUM_MASTERS (4),
      .PARK_MASTER (0),
      .GNT_TIMEOUT (16)
   ) dut (
      .Clock   (Clock),
      .RST     (RST),
      .Req     (Req),
      .Frame   (Frame),
      .Irdy    (Irdy),
      .Gnt     (Gnt),
      .Owner   (Owner),
      .BusIdle (BusIdle)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_own);
      n_total++;
      assert (Gnt === exp_gnt) n_pass++;
      else $error("FAIL %s gnt: observed %b expected %b", tag, Gnt, exp_gnt);
      n_total++;
      assert (Owner === exp_own) n_pass++;
      else $error("FAIL %s owner: observed %0d expected %0d", tag, Owner, exp_own);
   endtask

   task automatic check_idle(input string tag, input logic exp_idle);
      n_total++;
      assert (BusIdle === exp_idle) n_pass++;
      else $error("FAIL %s busidle: observed %b expected %b", tag, BusIdle, exp_idle);
   endtask

   initial begin
      RST = 1'b0; Req = 4'b1111; Frame = 1'b1; Irdy = 1'b1;
      tick(); tick();
      check("reset", 4'b1111, 2'd0);
      check_idle("reset", 1'b1);

      // Park on master 0 from the first edge out of reset.
      RST = 1'b1;
      tick(); check("park", 4'b1110, 2'd0);

      // Master 2 requests: gap, grant, busy until idle, then back to park via gap.
      Req = 4'b1011;
      tick(); check("t2_gap", 4'b1111, 2'd2);
      tick(); check("t2_grant", 4'b1011, 2'd2);
      Frame = 1'b0; Irdy = 1'b0;
      tick(); check("t2_busy", 4'b1011, 2'd2);
      check_idle("t2_busy", 1'b0);
      Frame = 1'b1; Irdy = 1'b0;
      tick(); check("t2_lastdata", 4'b1011, 2'd2);
      Req = 4'b1111; Frame = 1'b1; Irdy = 1'b1;
      tick(); check("t2_release", 4'b1111, 2'd0);
      check_idle("t2_release", 1'b1);
      tick(); check("t2_repark", 4'b1110, 2'd0);

      // Master 1 transaction moves ptr to 1; Frame low beats its Req going away.
      Req = 4'b1101;
      tick(); check("m1_gap", 4'b1111, 2'd1);
      tick(); check("m1_grant", 4'b1101, 2'd1);
      Frame = 1'b0; Irdy = 1'b0; Req = 4'b1111;
      tick(); check("frame_beats_req", 4'b1101, 2'd1);
      Frame = 1'b1; Irdy = 1'b1;
      tick(); check("m1_release", 4'b1111, 2'd0);
      tick(); check("m1_repark", 4'b1110, 2'd0);

      // Masters 1 and 3 with ptr=1: 3 first, then 1 after the bus goes idle.
      Req = 4'b0101;
      tick(); check("t3_gap3", 4'b1111, 2'd3);
      tick(); check("t3_grant3", 4'b0111, 2'd3);
      Frame = 1'b0; Irdy = 1'b0;
      tick(); check("t3_busy_release", 4'b1111, 2'd3);
      Frame = 1'b1; Irdy = 1'b1; Req = 4'b1101;
      tick(); check("t3_gap1", 4'b1111, 2'd1);
      tick(); check("t3_grant1", 4'b1101, 2'd1);
      Req = 4'b1111;
      tick(); check("t3_req_drop", 4'b1111, 2'd0);
      tick(); check("t3_repark", 4'b1110, 2'd0);

      // Master 2 holds Gnt on an idle bus until the timeout; ptr moves to 2 so 3 wins over 0.
      Req = 4'b1011;
      tick(); check("t4_gap", 4'b1111, 2'd2);
      tick(); check("t4_grant", 4'b1011, 2'd2);
      Req = 4'b0010;
      repeat (15) tick();
      check("t4_before_timeout", 4'b1011, 2'd2);
      tick(); check("t4_timeout", 4'b1111, 2'd3);
      tick(); check("t4_next", 4'b0111, 2'd3);

      // Master 3 leaves; 0 wins from ptr=2, runs a burst, Req[3] pulls Gnt[0].
      Req = 4'b1010;
      tick(); check("t5_gap0", 4'b1111, 2'd0);
      tick(); check("t5_grant0", 4'b1110, 2'd0);
      Frame = 1'b0; Irdy = 1'b0; Req = 4'b1110;
      tick(); check("t5_busy_hold", 4'b1110, 2'd0);
      Req = 4'b0110;
      tick(); check("t5_release", 4'b1111, 2'd0);
      Frame = 1'b1; Irdy = 1'b1; Req = 4'b0111;
      tick(); check("t5_gap3", 4'b1111, 2'd3);
      tick(); check("t5_grant3", 4'b0111, 2'd3);

      // Reset in the middle of master 1's transaction.
      Req = 4'b1101;
      tick(); check("t6_gap", 4'b1111, 2'd1);
      tick(); check("t6_grant", 4'b1101, 2'd1);
      Frame = 1'b0; Irdy = 1'b0;
      tick(); check("t6_busy", 4'b1101, 2'd1);
      RST = 1'b0;
      tick(); check("t6_reset", 4'b1111, 2'd0);
      check_idle("t6_reset", 1'b1);
      RST = 1'b1; Frame = 1'b1; Irdy = 1'b1; Req = 4'b1111;
      tick(); check("t6_park", 4'b1110, 2'd0);

      // Parked master starts on its own; a new request then pulls its Gnt.
      Frame = 1'b0; Irdy = 1'b0;
      tick(); check("park_busy", 4'b1110, 2'd0);
      check_idle("park_busy", 1'b0);
      Req = 4'b1011;
      tick(); check("park_busy_release", 4'b1111, 2'd0);
      Frame = 1'b1; Irdy = 1'b1;
      tick(); check("park_busy_gap", 4'b1111, 2'd2);
      tick(); check("park_busy_grant", 4'b1011, 2'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
